// File: rtl/pc_seq_if.sv
// Fetch-control bundle between the hazard/ID logic (master) and the PC sequencer (slave).
// Exception ports exist only when PC_SEQ_EXC_EN is defined.
interface pc_seq_if;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        pending;
    logic        adel;
`ifdef PC_SEQ_EXC_EN
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
`endif

`ifdef PC_SEQ_EXC_EN
    modport master (
        output stall, br_taken, br_target, jmp, jmp_target, exc_req, eret, epc,
        input  pc, pc_4, pending, adel
    );
    modport slave (
        input  stall, br_taken, br_target, jmp, jmp_target, exc_req, eret, epc,
        output pc, pc_4, pending, adel
    );
`else
    modport master (
        output stall, br_taken, br_target, jmp, jmp_target,
        input  pc, pc_4, pending, adel
    );
    modport slave (
        input  stall, br_taken, br_target, jmp, jmp_target,
        output pc, pc_4, pending, adel
    );
`endif
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer: sequential step, branch/jump redirect, and a one-deep
// redirect buffer held across stalls. PC_SEQ_EXC_EN adds exception entry and eret.
module pc_seq (
    input  logic     clk,
    input  logic     reset,
    pc_seq_if.slave  bus
);

    localparam logic [31:0] ResetPc = 32'h0000_3000;
`ifdef PC_SEQ_EXC_EN
    localparam logic [31:0] ExcVec  = 32'h0000_4180;
`endif

    typedef enum logic [0:0] {StRun, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        redir;
    logic [31:0] redir_tgt;

    // Redirect select: eret > jmp > br_taken.
    always_comb begin
        redir     = 1'b0;
        redir_tgt = bus.br_target;
`ifdef PC_SEQ_EXC_EN
        if (bus.eret) begin
            redir     = 1'b1;
            redir_tgt = bus.epc;
        end else
`endif
        if (bus.jmp) begin
            redir     = 1'b1;
            redir_tgt = bus.jmp_target;
        end else if (bus.br_taken) begin
            redir     = 1'b1;
            redir_tgt = bus.br_target;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        unique case (state_q)
            StRun: begin
                if (redir) begin
                    if (bus.stall) begin
                        pend_tgt_d = redir_tgt;
                        state_d    = StHold;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end else if (!bus.stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            StHold: begin
                // Redirect inputs are ignored while a target is buffered.
                if (!bus.stall) begin
                    pc_d    = pend_tgt_q;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
`ifdef PC_SEQ_EXC_EN
        if (bus.exc_req) begin
            pc_d       = ExcVec;
            pend_tgt_d = 32'd0;
            state_d    = StRun;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StRun;
            pc_q       <= ResetPc;
            pend_tgt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.pc_4    = pc_q + 32'd4;
    assign bus.pending = (state_q == StHold);
    assign bus.adel    = (pc_q[1:0] != 2'b00);

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL provide clk, input, 1: rising-edge clock; all state updates on this edge only.
REQ-002 SHALL provide reset, input, 1: reset is synchronous and active-low, sampled on the rising edge of clk.
REQ-003 SHALL provide stall, input, 1: hazard-unit hold request; when 1, the PC freezes.
REQ-004 SHALL provide br_taken, input, 1: resolved-taken branch from the ID stage.
REQ-005 SHALL provide br_target, input, 32: branch destination address.
REQ-006 SHALL provide jmp, input, 1: j/jal/jr/jalr redirect from the ID stage.
REQ-007 SHALL provide jmp_target, input, 32: jump destination address.
REQ-008 SHALL provide pc, output, 32: current fetch address, registered.
REQ-009 SHALL provide pc_4, output, 32: pc + 4, combinational from pc.
REQ-010 SHALL provide pending, output, 1: a redirect is latched and awaiting stall release.
REQ-011 SHALL provide adel, output, 1: pc[1:0] != 2'b00, combinational.

Function
REQ-012 SHALL implement a two-state FSM, RUN and HOLD, plus a 32-bit pend_tgt register.
REQ-013 Redirect priority SHALL be jmp > br_taken; when both are 1 in one cycle, the target SHALL be jmp_target.
REQ-014 In RUN with stall=0 and a redirect present, pc SHALL load the selected target next edge; the state SHALL remain RUN.
REQ-015 In RUN with stall=0 and no redirect, pc SHALL load pc + 4 next edge.
REQ-016 In RUN with stall=1 and no redirect, pc SHALL hold; the state SHALL remain RUN.
REQ-017 In RUN with stall=1 and a redirect present, the FSM SHALL latch the selected target into pend_tgt, hold pc, and enter HOLD.
REQ-018 In HOLD with stall=1, pc and pend_tgt SHALL hold; br_taken and jmp SHALL be ignored.
REQ-019 In HOLD with stall=0, pc SHALL load pend_tgt next edge and the FSM SHALL return to RUN; redirect inputs in that cycle SHALL be ignored.
REQ-020 pending SHALL be 1 exactly when the state is HOLD.
REQ-021 Addition SHALL be modulo 2^32: pc = 32'hFFFFFFFC gives pc_4 = 32'h00000000, and pc wraps to 0 on a sequential step.
REQ-022 Targets SHALL be loaded unmodified, with no alignment masking; misalignment SHALL be reported only via adel.
REQ-023 pc SHALL change at most once per clock; pc_4 SHALL reflect a new pc in the same cycle it updates.

Reset
REQ-024 reset=0 at an edge SHALL set pc=32'h00003000, state=RUN, pend_tgt=0 and pending=0, overriding all other inputs.
REQ-025 Reset asserted while in HOLD SHALL discard the latched target; the first fetch after release SHALL be 32'h00003000.
REQ-026 After reset, pc_4=32'h00003004 and adel=0.

Configuration
REQ-027 Macro PC_SEQ_EXC_EN SHALL gate exception support. When defined, it SHALL add the inputs exc_req (1), eret (1) and epc (32).
REQ-028 With PC_SEQ_EXC_EN, exc_req SHALL have the highest non-reset priority, overriding stall and HOLD.
REQ-029 With PC_SEQ_EXC_EN, exc_req SHALL set pc=32'h00004180, clear pending and force RUN.
REQ-030 With PC_SEQ_EXC_EN, eret SHALL be a redirect with target epc, ranking above jmp and below exc_req, and SHALL obey the stall/HOLD rules of REQ-014 to REQ-019.
REQ-031 Without PC_SEQ_EXC_EN, these ports and that logic SHALL be absent, and the behaviour SHALL be exactly REQ-012 to REQ-023.

Verification
REQ-032 Release reset, stall=0, no redirects, for 4 cycles -> pc sequence 3000, 3004, 3008, 300C; pending=0 throughout.
REQ-033 From pc=3008, br_taken=1, br_target=3100, stall=0 -> next pc=3100; then jmp=1 and br_taken=1 together with jmp_target=3200 -> next pc=3200.
REQ-034 stall=1 together with jmp=1, jmp_target=3400 for 3 cycles, with br_taken=1 and br_target=3500 in cycle 2 -> pc holds and pending=1; when stall drops, next pc=3400 and pending=0.
REQ-035 Preload a pending redirect, then assert reset=0 for one edge -> pc=3000, pending=0; after release, pc steps to 3004.
REQ-036 Force pc=FFFFFFFC -> pc_4=00000000 and next pc=00000000; jmp_target=3002 -> adel=1 on the following cycle.
REQ-037 With PC_SEQ_EXC_EN defined, exc_req=1 while in HOLD with stall=1 -> pc=4180, pending=0; then eret=1, epc=3010, stall=0 -> pc=3010.
